// File: rtl/trace_pkg.sv
// Shared record geometry and UART FSM encoding for the commit-trace transmitter.
package trace_pkg;

    localparam int unsigned REC_W          = 64;
    localparam int unsigned BYTES_PER_REC  = 8;
    localparam int unsigned BITS_PER_FRAME = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } tx_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO holding captured trace records.
module trace_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Record storage; contents are don't-care until written.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally; occupancy kept separately to tell full from empty.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/trace_uart_tx.sv
// Captures one {PC, write-data} record per PC change and sends it as eight 8N1 bytes, MSB byte first.
module trace_uart_tx
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     TraceEn,
    input  logic [31:0]              PCResult,
    input  logic [31:0]              WriteData,
    output logic                     Tx,
    output logic                     Busy,
    output logic [$clog2(DEPTH):0]   FifoCount,
    output logic [15:0]              DropCount,
    output logic                     Overflow
);

    localparam int unsigned CW        = $clog2(DEPTH) + 1;
    localparam int unsigned BW        = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIDX_W    = $clog2(BYTES_PER_REC);
    localparam int unsigned DATA_BITS = BITS_PER_FRAME - 2;

    logic             prev_valid;
    logic [31:0]      prev_pc;
    logic             capture;
    logic             push;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;
    logic [REC_W-1:0] fifo_dout;
    logic [CW-1:0]    fifo_count;

    tx_state_e        state;
    logic [REC_W-1:0] shreg;
    logic [7:0]       cur_byte;
    logic [BIDX_W-1:0] byte_idx;
    logic [2:0]       bit_cnt;
    logic [BW-1:0]    baud;
    logic             baud_done;
    logic             tx_q;
    logic             busy_q;
    logic [15:0]      drop_q;
    logic             ovf_q;

    assign capture   = TraceEn && (!prev_valid || (PCResult != prev_pc));
    assign pop       = (state == LOAD) && !empty;
    assign push      = capture && (!full || pop);
    assign drop      = capture && full && !pop;
    assign baud_done = (baud == BW'(CLKS_PER_BIT - 1));
    assign cur_byte  = shreg[REC_W-1 -: 8];

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (push),
        .pop   (pop),
        .din   ({PCResult, WriteData}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    // Last captured PC; updated on every capture, dropped or not, so a held PC never re-captures.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prev_valid <= 1'b0;
            prev_pc    <= '0;
        end else if (capture) begin
            prev_valid <= 1'b1;
            prev_pc    <= PCResult;
        end
    end

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    // UART framing FSM; Tx and Busy are set from the state being entered so both stay registered.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            shreg    <= '0;
            byte_idx <= '0;
            bit_cnt  <= '0;
            baud     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state   <= LOAD;
                        busy_q  <= 1'b1;
                        baud    <= '0;
                        bit_cnt <= '0;
                    end
                end
                LOAD: begin
                    shreg    <= fifo_dout;
                    byte_idx <= '0;
                    baud     <= '0;
                    bit_cnt  <= '0;
                    tx_q     <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        tx_q    <= cur_byte[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            tx_q    <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_q    <= cur_byte[3'(bit_cnt + 3'd1)];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        if (byte_idx != BIDX_W'(BYTES_PER_REC - 1)) begin
                            byte_idx <= byte_idx + BIDX_W'(1);
                            shreg    <= {shreg[REC_W-9:0], 8'h00};
                            tx_q     <= 1'b0;
                            state    <= START;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign Tx        = tx_q;
    assign Busy      = busy_q;
    assign FifoCount = fifo_count;
    assign DropCount = drop_q;
    assign Overflow  = ovf_q;

endmodule

// File: doc/trace_uart_tx.md
Name: trace_uart_tx

Overview:
- Observer for the datapath. Watches `PCResult`/`WriteData` and captures one 64-bit record per retired PC change.
- Buffers records in a small FIFO and serialises them off-chip as 8N1 UART bytes.
- This is the reading/transmitting end of the datapath's trace outputs, so on hardware the commit stream can be checked without a simulator.
- Instantiated beside `Datapath` at top level, on the same clock.

Parameters:
- `DEPTH`, 8: FIFO depth in records; must be a power of 2, minimum 2.
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); minimum 2.

Ports:
- `Clk`  in  1  system clock; all logic on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `TraceEn`  in  1  capture enable; when low, no new records are captured and transmission of queued records continues.
- `PCResult`  in  32  current PC from the datapath.
- `WriteData`  in  32  register-file write data from the datapath.
- `Tx`  out  1  UART serial line; idle high.
- `Busy`  out  1  high while the FSM is not in IDLE.
- `FifoCount`  out  $clog2(DEPTH)+1  number of queued records.
- `DropCount`  out  16  count of records lost to a full FIFO; saturates at 16'hFFFF.
- `Overflow`  out  1  sticky; set on the first drop, cleared only by reset.

Behaviour:
- Reset: applied asynchronously.
  - Outputs: `Tx`=1, `Busy`=0, `FifoCount`=0, `DropCount`=0, `Overflow`=0.
  - State: FIFO emptied, FSM forced to IDLE, `prev_valid`=0, `prev_pc`=0.
  - Reset mid-frame aborts the frame; `Tx` goes high immediately with no stop bit.
- Capture: on a rising edge where `TraceEn`=1 and (`prev_valid`=0 or `PCResult`≠`prev_pc`):
  - record = {`PCResult`, `WriteData`};
  - `prev_pc` <= `PCResult`, `prev_valid` <= 1.
  - `prev_pc` updates only on capture.
  - Repeated identical PC produces no records. A single PC value held across many cycles yields exactly one record.
- Push:
  - Record written on the capture edge if the FIFO is not full, or if it is full and a pop occurs on the same edge.
  - In that case the push is accepted and `FifoCount` is unchanged.
- Drop:
  - Full FIFO with no same-edge pop: record discarded.
  - `DropCount` += 1, saturating; `Overflow` <= 1.
  - `prev_pc` still updates, so the same PC is not re-captured later.
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE: `Tx`=1. If FIFO is non-empty, go to LOAD.
  - LOAD (1 cycle): pop head into a 64-bit shift register, `byte_idx`=0, then go to START.
  - START: `Tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: current byte sent LSB first, 8 bits of `CLKS_PER_BIT` cycles each, then STOP.
  - STOP: `Tx`=1 for `CLKS_PER_BIT` cycles. If `byte_idx`<7: `byte_idx`++, go to START. Else go to IDLE.
- Byte order: big-endian within the record.
  - Byte 0 = `PCResult`[31:24], …, byte 3 = `PCResult`[7:0].
  - Byte 4 = `WriteData`[31:24], …, byte 7 = `WriteData`[7:0].
- Latency and timing:
  - Capture on edge N with the FIFO empty and FSM in IDLE: FIFO non-empty after N; LOAD at N+1; `Tx` falls at edge N+2.
  - Record duration: 80×`CLKS_PER_BIT` cycles.
  - Back-to-back records have exactly 2 idle-high cycles between them (IDLE + LOAD).
- `Tx` is registered with no glitches. `Busy` = (state≠IDLE).
- Bit counter and baud counter are cleared on every state entry.
- FIFO pointers: `$clog2(DEPTH)` bits, wrapping naturally. `FifoCount` tracked separately.
  - full = (count==`DEPTH`); empty = (count==0).

Decomposition:
- `trace_pkg`:
  - `REC_W`=64, `BYTES_PER_REC`=8, `BITS_PER_FRAME`=10.
  - FSM state localparams: IDLE=0, LOAD=1, START=2, DATA=3, STOP=4, 3-bit.
- Sub-module `trace_fifo`:
  - Parameterised synchronous FIFO with `WIDTH`=`REC_W` and `DEPTH`.
  - Ports: push/pop/din/dout/count/full/empty.
  - Async active-high `Reset`.
  - Dout shows the head (first-word fall-through).
- Capture logic, drop counter and UART FSM live in `trace_uart_tx`.

Test Plan:
- Single record: `CLKS_PER_BIT`=4, `TraceEn`=1, `PCResult` 0→0x00000004 with `WriteData`=0x0000002A.
  - Two records: first at reset release (PC 0x0), then PC 0x4.
  - The PC 0x4 record decodes to bytes 00 00 00 04 00 00 00 2A.
  - Each frame: start bit low, LSB-first data, stop bit high, 40 cycles per byte.
- Hold: `PCResult` held at 0x00400000 for 100 cycles.
  - Exactly one record queued; `FifoCount` peaks at 1.
- Overflow: `DEPTH`=4, 10 distinct PCs on consecutive cycles while the first record is being sent.
  - `FifoCount` reaches 4; `DropCount`=5; `Overflow`=1.
  - Exactly 5 records emerge on `Tx`, in order.
- Back-to-back: 2 records queued.
  - Exactly 2 idle-high cycles between the last stop bit of record 1 and the start bit of record 2.
  - `Busy` low for exactly 1 cycle.
- Reset mid-frame: assert `Reset` during DATA bit 3 of byte 2.
  - `Tx`=1 within the same cycle; `FifoCount`=0; `Busy`=0.
  - After release, a new PC 0x8 is captured as the first record and sent cleanly.
- `TraceEn`=0 with 3 PC changes: no records queued.
  - Then `TraceEn`=1 with PC unchanged: one record captured (because `prev_valid`=0 after reset).
